// File: rtl/ycr1_wb_arb2_pkg.sv
// ============================================================================
// Module      : ycr1_wb_arb2_pkg
// Description : Shared Wishbone width, timeout default and arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ycr1_wb_arb2_pkg;

  localparam int YCR1_WB_WIDTH   = 32;
  localparam int YCR1_WB_TMO_CYC = 256;

  typedef enum logic [1:0] {
    WB_ARB_IDLE = 2'd0,
    WB_ARB_GNT0 = 2'd1,
    WB_ARB_GNT1 = 2'd2
  } type_ycr1_wb_arb_state_e;

endpackage : ycr1_wb_arb2_pkg

`default_nettype wire

// File: rtl/ycr1_wb_arb2.sv
// ============================================================================
// Module      : ycr1_wb_arb2
// Description : Round-robin two-master Wishbone arbiter with per-transfer timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ycr1_wb_arb2
  import ycr1_wb_arb2_pkg::*;
#(
  parameter int AW      = YCR1_WB_WIDTH,
  parameter int TMO_CYC = YCR1_WB_TMO_CYC,
  parameter int TW      = $clog2(TMO_CYC + 1)
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          m0_wbd_stb_i,
  input  logic [AW-1:0] m0_wbd_adr_i,
  output logic          m0_wbd_ack_o,
  output logic          m0_wbd_err_o,
  input  logic          m1_wbd_stb_i,
  input  logic [AW-1:0] m1_wbd_adr_i,
  input  logic          m1_wbd_we_i,
  input  logic [AW-1:0] m1_wbd_dat_i,
  input  logic [3:0]    m1_wbd_sel_i,
  output logic          m1_wbd_ack_o,
  output logic          m1_wbd_err_o,
  output logic [AW-1:0] m_wbd_dat_o,
  output logic          wbd_stb_o,
  output logic [AW-1:0] wbd_adr_o,
  output logic          wbd_we_o,
  output logic [AW-1:0] wbd_dat_o,
  output logic [3:0]    wbd_sel_o,
  input  logic [AW-1:0] wbd_dat_i,
  input  logic          wbd_ack_i,
  input  logic          wbd_err_i
);

  // TW collapses to 0 when the timeout is disabled; keep the counter at least 1 bit.
  localparam int            CW       = (TW < 1) ? 1 : TW;
  localparam bit            TMO_EN   = (TMO_CYC > 0);
  localparam logic [CW-1:0] TMO_LAST = TMO_EN ? CW'(TMO_CYC - 1) : '0;

  type_ycr1_wb_arb_state_e r_state;
  type_ycr1_wb_arb_state_e w_state_nxt;
  logic                    r_rr_last;
  logic [CW-1:0]           r_tmo_cnt;
  logic                    w_rsp;
  logic                    w_tmo;

  assign w_rsp = wbd_ack_i | wbd_err_i;
  assign w_tmo = TMO_EN && (r_state != WB_ARB_IDLE) && !w_rsp && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state   <= WB_ARB_IDLE;
      r_rr_last <= 1'b1;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == WB_ARB_IDLE) begin
        if (w_state_nxt == WB_ARB_GNT0) r_rr_last <= 1'b0;
        if (w_state_nxt == WB_ARB_GNT1) r_rr_last <= 1'b1;
      end
      // Idle always separates two grants, so clearing here clears on every entry.
      if (r_state == WB_ARB_IDLE) r_tmo_cnt <= '0;
      else if (TMO_EN)            r_tmo_cnt <= r_tmo_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      WB_ARB_IDLE: begin
        if (m0_wbd_stb_i && (!m1_wbd_stb_i || r_rr_last)) w_state_nxt = WB_ARB_GNT0;
        else if (m1_wbd_stb_i)                            w_state_nxt = WB_ARB_GNT1;
      end
      WB_ARB_GNT0: begin
        if (!m0_wbd_stb_i || w_rsp || w_tmo) w_state_nxt = WB_ARB_IDLE;
      end
      WB_ARB_GNT1: begin
        if (!m1_wbd_stb_i || w_rsp || w_tmo) w_state_nxt = WB_ARB_IDLE;
      end
      default: w_state_nxt = WB_ARB_IDLE;
    endcase
  end

  always_comb begin
    m0_wbd_ack_o = 1'b0;
    m0_wbd_err_o = 1'b0;
    m1_wbd_ack_o = 1'b0;
    m1_wbd_err_o = 1'b0;
    m_wbd_dat_o  = '0;
    wbd_stb_o    = 1'b0;
    wbd_adr_o    = '0;
    wbd_we_o     = 1'b0;
    wbd_dat_o    = '0;
    wbd_sel_o    = 4'b0000;
    unique case (r_state)
      WB_ARB_GNT0: begin
        wbd_stb_o    = 1'b1;
        wbd_adr_o    = m0_wbd_adr_i;
        wbd_sel_o    = 4'b1111;
        m0_wbd_ack_o = wbd_ack_i;
        m0_wbd_err_o = wbd_err_i | w_tmo;
        if (wbd_ack_i) m_wbd_dat_o = wbd_dat_i;
      end
      WB_ARB_GNT1: begin
        wbd_stb_o    = 1'b1;
        wbd_adr_o    = m1_wbd_adr_i;
        wbd_we_o     = m1_wbd_we_i;
        wbd_dat_o    = m1_wbd_dat_i;
        wbd_sel_o    = m1_wbd_sel_i;
        m1_wbd_ack_o = wbd_ack_i;
        m1_wbd_err_o = wbd_err_i | w_tmo;
        if (wbd_ack_i) m_wbd_dat_o = wbd_dat_i;
      end
      default: begin
      end
    endcase
  end

endmodule : ycr1_wb_arb2

`default_nettype wire

// File: tb/tb_ycr1_wb_arb2.sv
// ============================================================================
// Module      : tb_ycr1_wb_arb2
// Description : Self-checking bench for the two-master Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ycr1_wb_arb2;

  localparam int AW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_stb = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0, m1_dat = '0, s_dat = '0;
  logic [3:0]    m1_sel = '0;
  logic          s_ack = 1'b0, s_err = 1'b0;
  logic          m0_ack, m0_err, m1_ack, m1_err, stb_o, we_o;
  logic [AW-1:0] mdat_o, adr_o, dat_o;
  logic [3:0]    sel_o;

  int checks = 0;
  int errors = 0;
  int exp_last;

  always #5 clk = ~clk;

  ycr1_wb_arb2 #(.AW(AW), .TMO_CYC(TMO)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .m0_wbd_stb_i(m0_stb), .m0_wbd_adr_i(m0_adr),
    .m0_wbd_ack_o(m0_ack), .m0_wbd_err_o(m0_err),
    .m1_wbd_stb_i(m1_stb), .m1_wbd_adr_i(m1_adr), .m1_wbd_we_i(m1_we),
    .m1_wbd_dat_i(m1_dat), .m1_wbd_sel_i(m1_sel),
    .m1_wbd_ack_o(m1_ack), .m1_wbd_err_o(m1_err),
    .m_wbd_dat_o(mdat_o),
    .wbd_stb_o(stb_o), .wbd_adr_o(adr_o), .wbd_we_o(we_o),
    .wbd_dat_o(dat_o), .wbd_sel_o(sel_o),
    .wbd_dat_i(s_dat), .wbd_ack_i(s_ack), .wbd_err_i(s_err)
  );

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_slave(input string tag, input int who);
    chk({tag, "_stb"}, {31'd0, stb_o}, 32'd1);
    chk({tag, "_adr"}, adr_o, (who == 0) ? m0_adr : m1_adr);
    chk({tag, "_we"},  {31'd0, we_o},  (who == 0) ? 32'd0 : {31'd0, m1_we});
    chk({tag, "_dat"}, dat_o, (who == 0) ? 32'd0 : m1_dat);
    chk({tag, "_sel"}, {28'd0, sel_o}, (who == 0) ? 32'hF : {28'd0, m1_sel});
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rsp"}, {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    chk({tag, "_mdat"}, mdat_o, 32'd0);
  endtask

  // One complete transfer: winner chosen from the round-robin rule, then
  // wait_n empty granted cycles, then the chosen slave response.
  task automatic xfer(input bit r0, input bit r1, input int wait_n, input int resp);
    int  who;
    bit  a, e;
    who = (r0 && r1) ? ((exp_last == 0) ? 1 : 0) : (r0 ? 0 : 1);
    exp_last = who;
    m0_stb = r0; m0_adr = $urandom;
    m1_stb = r1; m1_adr = $urandom; m1_dat = $urandom;
    m1_we = 1'($urandom_range(0, 1)); m1_sel = 4'($urandom_range(0, 15));
    #1 chk("x_idle_stb", {31'd0, stb_o}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < wait_n; k++) begin
      s_dat = $urandom;
      #1 chk_slave("x_wait", who);
      chk_quiet("x_wait");
      @(negedge clk);
    end
    a = (resp != 1);
    e = (resp != 0);
    s_ack = a; s_err = e; s_dat = $urandom;
    #1 chk_slave("x_gnt", who);
    chk("x_rsp", {28'd0, m0_ack, m0_err, m1_ack, m1_err},
        (who == 0) ? {28'd0, a, e, 2'b00} : {28'd0, 2'b00, a, e});
    chk("x_mdat", mdat_o, a ? s_dat : 32'd0);
    @(negedge clk);
    m0_stb = 0; m1_stb = 0; s_ack = 0; s_err = 0;
    #1 chk("x_bubble_stb", {31'd0, stb_o}, 32'd0);
    chk_quiet("x_bubble");
  endtask

  initial begin
    int n0, n1, xfers, cyc, who;
    exp_last = 1;
    s_dat = 32'hCAFE_F00D;
    #2 chk("rst_stb", {31'd0, stb_o}, 32'd0);
    chk_quiet("rst");
    chk("rst_adr", adr_o, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Continuous contention with a zero-wait slave: strict alternation, m0 first.
    m0_adr = 32'h0000_1000; m1_adr = 32'h0000_2000; m1_we = 0; m1_sel = 4'hF;
    m0_stb = 1; m1_stb = 1;
    n0 = 0; n1 = 0; xfers = 0; cyc = 0;
    while (xfers < 100 && cyc < 400) begin
      cyc++;
      s_ack = stb_o; s_dat = $urandom;
      #1;
      if (stb_o) begin
        who = (exp_last == 0) ? 1 : 0;
        exp_last = who;
        chk("rr_owner", {30'd0, m0_ack, m1_ack}, (who == 0) ? 32'd2 : 32'd1);
        chk("rr_data", mdat_o, s_dat);
        if (who == 0) n0++; else n1++;
        xfers++;
      end
      @(negedge clk);
    end
    m0_stb = 0; m1_stb = 0; s_ack = 0;
    chk("rr_cycles", cyc, 200);
    chk("rr_m0_count", n0, 50);
    chk("rr_m1_count", n1, 50);
    @(negedge clk);

    // Directed m0 read with three wait cycles.
    m0_stb = 1; m0_adr = 32'h0000_0100;
    #1 chk("m0rd_lat", {31'd0, stb_o}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1 chk_slave("m0rd_wait", 0);
      chk_quiet("m0rd_wait");
      @(negedge clk);
    end
    s_ack = 1; s_dat = 32'hDEAD_BEEF;
    #1 chk("m0rd_ack", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'h8);
    chk("m0rd_data", mdat_o, 32'hDEAD_BEEF);
    exp_last = 0;
    @(negedge clk);
    m0_stb = 0; s_ack = 0;
    #1 chk("m0rd_done", {31'd0, stb_o}, 32'd0);
    @(negedge clk);

    // Directed m1 write.
    m1_stb = 1; m1_adr = 32'h2000_0004; m1_dat = 32'h1234_5678; m1_we = 1; m1_sel = 4'b0011;
    @(negedge clk);
    #1 chk_slave("m1wr", 1);
    s_ack = 1;
    #1 chk("m1wr_ack", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'h2);
    exp_last = 1;
    @(negedge clk);
    m1_stb = 0; s_ack = 0;
    @(negedge clk);

    // Timeout on m1, then a late ack that must be dropped.
    m1_stb = 1; m1_we = 0;
    @(negedge clk);
    for (int k = 1; k <= TMO; k++) begin
      #1 chk("tmo_stb", {31'd0, stb_o}, 32'd1);
      chk("tmo_err", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, (k == TMO) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    m1_stb = 0;
    #1 chk("tmo_release", {31'd0, stb_o}, 32'd0);
    @(negedge clk);
    s_ack = 1; s_dat = 32'h5555_AAAA;
    #1 chk_quiet("tmo_late_ack");
    @(negedge clk);
    s_ack = 0;
    exp_last = 1;

    // Slave error on an m0 read, then an ordinary m1 request.
    m0_stb = 1; m0_adr = 32'h0000_0040;
    @(negedge clk);
    s_err = 1;
    #1 chk("err_m0", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'h4);
    exp_last = 0;
    @(negedge clk);
    m0_stb = 0; s_err = 0;
    xfer(0, 1, 0, 0);

    // Master abort: m0 drops stb while granted.
    m0_stb = 1; m0_adr = 32'h0000_0080;
    @(negedge clk);
    #1 chk_slave("abort_gnt", 0);
    m0_stb = 0;
    exp_last = 0;
    @(negedge clk);
    #1 chk("abort_stb", {31'd0, stb_o}, 32'd0);
    chk_quiet("abort");
    @(negedge clk);

    // Randomized traffic against the transaction-level round-robin model.
    for (int t = 0; t < 40; t++) begin
      int pick;
      pick = $urandom_range(0, 2);
      xfer(pick != 1, pick != 0, $urandom_range(0, 5), $urandom_range(0, 2));
      @(negedge clk);
    end

    // Asynchronous reset while m1 owns the bus.
    m1_stb = 1; m1_adr = 32'h3000_0000;
    @(negedge clk);
    #1 chk_slave("rstgnt", 1);
    #1 rst_n = 0; s_ack = 1;
    #1 chk("rstmid_stb", {31'd0, stb_o}, 32'd0);
    chk("rstmid_adr", adr_o, 32'd0);
    chk_quiet("rstmid");
    @(negedge clk);
    rst_n = 1; m0_stb = 1; m0_adr = 32'h0000_0300;
    exp_last = 1;
    #1 chk_quiet("rstrel_drop");
    @(negedge clk);
    s_ack = 0;
    #1 chk_slave("rstrel_tie", 0);
    m0_stb = 0; m1_stb = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_ycr1_wb_arb2

`default_nettype wire

// File: doc/ycr1_wb_arb2.md
Name:
ycr1_wb_arb2

Overview:
Two-master to one-slave Wishbone arbiter in the wb_clk domain. It shares one Wishbone port between the imem bridge (master 0, read-only) and the dmem bridge (master 1, read/write). It uses round-robin grant, holds the grant until the slave responds, and has a per-transfer timeout that returns an error to the granted master.

Parameters:
AW, 32, address/data width (YCR1_WB_WIDTH)
TMO_CYC, 256, maximum cycles a granted transfer waits for ack/err; 0 disables timeout
TW, $clog2(TMO_CYC+1), timeout counter width (derived, not overridden)

Ports:
wb_clk  input  1  wishbone clock
wb_rst_n  input  1  asynchronous active-low reset
m0_wbd_stb_i  input  1  imem master request
m0_wbd_adr_i  input  AW  imem master address
m0_wbd_ack_o  output  1  imem master acknowledge
m0_wbd_err_o  output  1  imem master error
m1_wbd_stb_i  input  1  dmem master request
m1_wbd_adr_i  input  AW  dmem master address
m1_wbd_we_i  input  1  dmem master write enable
m1_wbd_dat_i  input  AW  dmem master write data
m1_wbd_sel_i  input  4  dmem master byte enables
m1_wbd_ack_o  output  1  dmem master acknowledge
m1_wbd_err_o  output  1  dmem master error
m_wbd_dat_o  output  AW  read data broadcast to both masters; valid only with the owner's ack
wbd_stb_o  output  1  slave strobe
wbd_adr_o  output  AW  slave address
wbd_we_o  output  1  slave write enable
wbd_dat_o  output  AW  slave write data
wbd_sel_o  output  4  slave byte enables
wbd_dat_i  input  AW  slave read data
wbd_ack_i  input  1  slave acknowledge
wbd_err_i  input  1  slave error

Behaviour:
- FSM states: IDLE, GNT0, GNT1; state, rr_last (last granted master) and tmo_cnt are registered.
- Reset values: state=IDLE, rr_last=1 (so m0 wins the first tie), tmo_cnt=0. All outputs are 0 in reset and in IDLE.
- IDLE: if exactly one stb is high, go to GNTx next cycle. If both are high, grant the master that is not rr_last. Arbitration latency is 1 cycle: stb seen in cycle N gives wbd_stb_o=1 in cycle N+1.
- GNTx: slave outputs come from master x; m0 forces we=0, dat=0, sel=4'b1111. rr_last<=x on entry. tmo_cnt clears on entry and increments each GNTx cycle.
- In GNTx, wbd_ack_i or wbd_err_i produces a same-cycle combinational mx_ack_o=ack_i and mx_err_o=err_i, with m_wbd_dat_o=wbd_dat_i. The next state is IDLE, so there is one idle bubble per transfer. This bubble lets the master drop or advance stb.
- ack and err both high: pass both through unchanged; the master resolves them (err dominates in the bridges).
- Timeout: TMO_CYC>0 and tmo_cnt==TMO_CYC-1 without ack/err produces mx_err_o=1 for that cycle, wbd_stb_o deasserts next cycle, and the state returns to IDLE. A late slave ack arriving in IDLE is dropped and routed to neither master.
- Master abort: if the granted mx_stb_i drops before ack, go to IDLE next cycle with no ack/err. wbd_stb_o follows the grant for that cycle.
- Non-owner ack/err outputs stay 0 at all times. m_wbd_dat_o is 0 when no ack is being routed, which keeps X off the idle path.
- Asynchronous reset mid-transfer: immediate return to IDLE with outputs 0; any slave response after reset release is dropped.
- Back-to-back with both requesting: grants alternate 0,1,0,1 with a 2-cycle period per transfer for zero-wait slaves.

Decomposition:
- The state enum (type_ycr1_wb_arb_state_e) and the TMO_CYC default belong in ycr1_wb.svh next to YCR1_WB_WIDTH.
- No sub-module; the arbiter, mux and timeout counter live in one module.

Test Plan:
- Only m0 requests, adr=0x0000_0100, slave acks after 3 cycles -> wbd_stb_o rises 1 cycle after m0 stb with adr=0x100, sel=F, we=0; m0_ack_o pulses once with data=0xDEADBEEF; m1_ack_o stays 0.
- m0 and m1 request continuously, 0-wait slave -> grants alternate m0,m1,m0,m1 (m0 first after reset); each transfer takes 2 cycles; no master is starved over 100 transfers.
- m1 write, adr=0x2000_0004, dat=0x1234_5678, sel=0011 -> slave sees exactly those values with we=1; m1_ack_o pulses once.
- TMO_CYC=8, slave never acks -> m1_err_o=1 in the 8th granted cycle; wbd_stb_o=0 next cycle; a late ack in cycle 10 reaches neither master.
- Slave returns err on an m0 read -> m0_err_o=1 in the same cycle, then IDLE; the next m1 request is granted normally.
- wb_rst_n asserted while in GNT1 -> all outputs 0 immediately; after release the first grant goes to m0 on a tie.
